// File: rtl/harris_pkg.sv
`default_nettype none
// ============================================================================
// Module   : harris_pkg
// Brief    : Shared widths, defaults and sequencer state type for the
//            harris_stream_ctrl frame sequencer.
// Revision : 1.0
// ============================================================================
package harris_pkg;

    localparam int PIX_W     = 8;
    localparam int SCORE_W   = 32;
    localparam int WIN       = 6;
    localparam int DEF_IMG_W = 64;
    localparam int DEF_IMG_H = 64;
    localparam int DEF_LAT   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/harris_coord_delay.sv
`default_nettype none
// ============================================================================
// Module   : harris_coord_delay
// Brief    : Fixed-depth shift register of {valid, x, y} with synchronous clear.
// Revision : 1.0
// ============================================================================
module harris_coord_delay #(
    parameter int DEPTH = 4,
    parameter int XW    = 6,
    parameter int YW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_valid,
    input  logic [XW-1:0] i_x,
    input  logic [YW-1:0] i_y,
    output logic          o_valid,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y
);

    logic [DEPTH-1:0] r_valid;
    logic [XW-1:0]    r_x [DEPTH];
    logic [YW-1:0]    r_y [DEPTH];

    // Shifts unconditionally so a gap in the input stream travels as an invalid slot.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            r_valid <= {r_valid[DEPTH-2:0], i_valid};
            r_x[0]  <= i_x;
            r_y[0]  <= i_y;
            for (int i = 1; i < DEPTH; i++) begin
                r_x[i] <= r_x[i-1];
                r_y[i] <= r_y[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_x     = r_x[DEPTH-1];
    assign o_y     = r_y[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/harris_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : harris_stream_ctrl
// Brief    : Feeds one raster frame to the Harris detector and pairs each
//            returned score with its pixel coordinate and border flag.
// Revision : 1.0
// ============================================================================
module harris_stream_ctrl #(
    parameter int  IMG_W = harris_pkg::DEF_IMG_W,
    parameter int  IMG_H = harris_pkg::DEF_IMG_H,
    parameter int  WIN   = harris_pkg::WIN,
    parameter int  LAT   = harris_pkg::DEF_LAT,
    localparam int CW    = $clog2(IMG_W),
    localparam int RW    = $clog2(IMG_H)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           in_valid,
    input  logic [harris_pkg::PIX_W-1:0]   in_pixel,
    output logic                           in_ready,
    output logic [harris_pkg::PIX_W-1:0]   pix_out,
    output logic                           pix_valid_out,
    input  logic [harris_pkg::SCORE_W-1:0] score_in,
    output logic                           out_valid,
    output logic [CW-1:0]                  out_x,
    output logic [RW-1:0]                  out_y,
    output logic [harris_pkg::SCORE_W-1:0] out_score,
    output logic                           out_border,
    output logic                           busy,
    output logic                           frame_done
);

    import harris_pkg::*;

    localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_win_x    = CW'(WIN - 1);
    localparam logic [RW-1:0] c_win_y    = RW'(WIN - 1);

    state_t        r_state;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    logic          w_hs;
    logic          w_push;
    logic          w_last_px;
    logic          w_dl_valid;
    logic [CW-1:0] w_dl_x;
    logic [RW-1:0] w_dl_y;
    logic          w_border;

    assign w_hs      = in_valid & in_ready;
    assign w_push    = w_hs & ~abort;
    assign w_last_px = (r_col == c_col_last) && (r_row == c_row_last);
    assign w_border  = (w_dl_x < c_win_x) || (w_dl_y < c_win_y);
    assign busy      = (r_state != IDLE);

    // LAT+1 stages: the final stage lines up with score_in for the same pixel.
    harris_coord_delay #(
        .DEPTH (LAT + 1),
        .XW    (CW),
        .YW    (RW)
    ) u_coord_delay (
        .clk     (clk),
        .rst     (reset),
        .i_clear (abort),
        .i_valid (w_push),
        .i_x     (r_col),
        .i_y     (r_row),
        .o_valid (w_dl_valid),
        .o_x     (w_dl_x),
        .o_y     (w_dl_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_col         <= '0;
            r_row         <= '0;
            in_ready      <= 1'b0;
            pix_out       <= '0;
            pix_valid_out <= 1'b0;
            out_valid     <= 1'b0;
            out_x         <= '0;
            out_y         <= '0;
            out_score     <= '0;
            out_border    <= 1'b0;
            frame_done    <= 1'b0;
        end else if (abort) begin
            r_state       <= IDLE;
            in_ready      <= 1'b0;
            pix_valid_out <= 1'b0;
            out_valid     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            pix_valid_out <= 1'b0;
            frame_done    <= 1'b0;
            out_valid     <= w_dl_valid;
            if (w_dl_valid) begin
                out_x      <= w_dl_x;
                out_y      <= w_dl_y;
                out_border <= w_border;
                out_score  <= w_border ? '0 : score_in;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= STREAM;
                        r_col    <= '0;
                        r_row    <= '0;
                        in_ready <= 1'b1;
                    end
                end
                STREAM: begin
                    if (w_hs) begin
                        pix_out       <= in_pixel;
                        pix_valid_out <= 1'b1;
                        if (w_last_px) begin
                            r_state  <= DRAIN;
                            in_ready <= 1'b0;
                        end
                        if (r_col == c_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Only the final pixel of the frame can appear here with these coordinates.
                    if (out_valid && (out_x == c_col_last) && (out_y == c_row_last)) begin
                        frame_done <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_harris_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_harris_stream_ctrl
// Brief    : Randomised scoreboard bench for harris_stream_ctrl with a
//            behavioural detector model (score = 1000*y + x).
// Revision : 1.0
// ============================================================================
module tb_harris_stream_ctrl;

    localparam int W   = 8;
    localparam int H   = 8;
    localparam int WIN = 6;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_pixel = 8'd0;
    logic        in_ready;
    logic [7:0]  pix_out;
    logic        pix_valid_out;
    logic [31:0] score_in;
    logic        out_valid;
    logic [2:0]  out_x;
    logic [2:0]  out_y;
    logic [31:0] out_score;
    logic        out_border;
    logic        busy;
    logic        frame_done;

    harris_stream_ctrl #(.IMG_W(W), .IMG_H(H), .WIN(WIN), .LAT(LAT)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .in_valid      (in_valid),
        .in_pixel      (in_pixel),
        .in_ready      (in_ready),
        .pix_out       (pix_out),
        .pix_valid_out (pix_valid_out),
        .score_in      (score_in),
        .out_valid     (out_valid),
        .out_x         (out_x),
        .out_y         (out_y),
        .out_score     (out_score),
        .out_border    (out_border),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Detector model: pixel value is the raster index, score appears LAT cycles later.
    logic [31:0] det_q [LAT];
    always @(posedge clk) begin
        det_q[0] <= pix_valid_out ? 32'(1000 * (int'(pix_out) / W) + int'(pix_out) % W)
                                  : $urandom;
        for (int i = 1; i < LAT; i++) det_q[i] <= det_q[i-1];
    end
    assign score_in = det_q[LAT-1];

    typedef struct {
        int     x;
        int     y;
        int     border;
        int     score;
        longint cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    bit   prev_last = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, req);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("out_x", out_x, e.x);
                    check("out_y", out_y, e.y);
                    check("out_border", out_border, e.border);
                    check("out_score", out_score, e.score);
                    check("out_cycle", cyc, e.cyc);
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_done_after_last", prev_last, 1);
            end
            prev_last = out_valid && (out_x == 3'(W - 1)) && (out_y == 3'(H - 1));
        end
    end

    task automatic run_frame(input int pct, input int abort_at, input bit poke_start);
        int   n = 0;
        int   guard = 0;
        int   d0;
        exp_t e;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("in_ready_after_start", in_ready, 1);
        check("busy_after_start", busy, 1);
        while (n < W * H && guard < 4000) begin
            guard++;
            in_valid = ($urandom_range(99) < pct);
            in_pixel = 8'(n);
            start    = poke_start && ($urandom_range(7) == 0);
            if (n == abort_at) begin
                abort    = 1'b1;
                in_valid = 1'b1;
            end
            if (!abort && in_valid && in_ready) begin
                e.x      = n % W;
                e.y      = n / W;
                e.border = (e.x < WIN - 1 || e.y < WIN - 1) ? 1 : 0;
                e.score  = e.border ? 0 : 1000 * e.y + e.x;
                e.cyc    = cyc + LAT + 2;
                sb.push_back(e);
                n++;
            end
            @(negedge clk);
            start = 1'b0;
            if (abort) begin
                abort    = 1'b0;
                in_valid = 1'b0;
                check("abort_in_ready", in_ready, 0);
                check("abort_pix_valid", pix_valid_out, 0);
                check("abort_out_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                sb.delete();
                d0 = done_cnt;
                repeat (12) @(negedge clk);
                check("abort_no_frame_done", done_cnt, d0);
                return;
            end
        end
        check("stream_complete", n, W * H);
        in_valid = 1'b0;
        d0 = done_cnt;
        guard = 0;
        while (done_cnt == d0 && guard < 100) begin
            start = poke_start && ($urandom_range(3) == 0);
            @(negedge clk);
            start = 1'b0;
            guard++;
        end
        check("frame_done_seen", done_cnt, d0 + 1);
        repeat (3) @(negedge clk);
        check("frame_done_single", done_cnt, d0 + 1);
        check("busy_after_frame", busy, 0);
        check("in_ready_after_frame", in_ready, 0);
        check("all_results_seen", sb.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_pix_valid", pix_valid_out, 0);
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
            check("idle_pix_valid", pix_valid_out, 0);
        end
        in_valid = 1'b0;

        run_frame(100, -1, 1'b0);
        run_frame(50,  -1, 1'b0);
        run_frame(100, 30, 1'b0);
        run_frame(100, -1, 1'b0);
        run_frame(80,  -1, 1'b1);
        run_frame(30,  -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
